// File: rtl/lif_pkg.sv
// lif_pkg
// Shared definitions for the leaky integrate-and-fire neuron bank:
//   state_t        - controller states (INIT sweep, RUN)
//   RESET_TO_ZERO  - reset_mode value: membrane cleared after a spike
//   RESET_SUBTRACT - reset_mode value: threshold subtracted after a spike
//   clog2()        - ceiling log2, used to size neuron index buses
package lif_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic RESET_TO_ZERO  = 1'b0;
   localparam logic RESET_SUBTRACT = 1'b1;

   // Number of bits needed to hold the values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result = result + 1;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/lif_state_ram.sv
// lif_state_ram
// Simple dual-port state memory with a registered read port.
//   clk     - clock, both ports on its rising edge
//   rd_en   - read strobe; rd_data updates on the next edge
//   rd_addr - read address
//   rd_data - registered read data
//   wr_en   - write strobe
//   wr_addr - write address
//   wr_data - write data
// Contents are never reset; the neuron bank zeroes them with its init sweep.
module lif_state_ram #(
   parameter int DATA_W = 29,
   parameter int DEPTH  = 589,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/lif_neuron_bank.sv
// lif_neuron_bank
// Time-multiplexed bank of leaky integrate-and-fire neurons. Each accepted
// beat updates neuron index ptr in every lane; ptr walks 0..DEPTH-1 and wraps.
// Pipeline: beat accepted -> (1) state read + input register
//                         -> (2) compute, output register, write-back.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clr                 - synchronous restart: flush pipeline, redo init sweep
//   in_valid, in_ready  - input handshake (in_ready low during init sweep)
//   in_current          - signed current per lane, lane 0 in the LSBs
//   decay               - leak factor decay/2^DECAY_W
//   threshold           - signed firing threshold
//   refrac_len          - refractory steps after a spike
//   reset_mode          - post-spike behaviour (see lif_pkg)
//   out_valid           - result strobe
//   out_spike, out_vmem - per-lane spike and updated membrane value
//   out_idx             - neuron index of the result
//   step_done           - pulses with the result for index DEPTH-1
module lif_neuron_bank
   import lif_pkg::*;
#(
   parameter int WIDTH    = 25,
   parameter int DEPTH    = 589,
   parameter int LANES    = 1,
   parameter int DECAY_W  = 14,
   parameter int REFRAC_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*WIDTH-1:0]    in_current,
   input  logic [DECAY_W-1:0]        decay,
   input  logic [WIDTH-1:0]          threshold,
   input  logic [REFRAC_W-1:0]       refrac_len,
   input  logic                      reset_mode,
   output logic                      out_valid,
   output logic [LANES-1:0]          out_spike,
   output logic [LANES*WIDTH-1:0]    out_vmem,
   output logic [clog2(DEPTH)-1:0]   out_idx,
   output logic                      step_done
);

   localparam int IDX_W  = clog2(DEPTH);
   localparam int WORD_W = WIDTH + REFRAC_W;
   localparam int RAM_W  = LANES * WORD_W;
   localparam int PROD_W = WIDTH + DECAY_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic signed [WIDTH-1:0] VMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] VMIN = {1'b1, {(WIDTH-1){1'b0}}};

   if (DEPTH < 3) begin : g_depth_check
      $error("lif_neuron_bank: DEPTH must be 3 or more");
   end

   state_t                 state;
   logic [IDX_W-1:0]       ptr;
   logic                   accept;
   logic                   s1_valid, s2_valid;
   logic [IDX_W-1:0]       s1_idx, s2_idx;
   logic [LANES*WIDTH-1:0] s1_current, s2_current;
   logic [RAM_W-1:0]       rd_data;
   logic                   wr_en;
   logic [IDX_W-1:0]       wr_addr;
   logic [RAM_W-1:0]       wr_data;
   logic [RAM_W-1:0]       wr_word;
   logic [LANES*WIDTH-1:0] next_vmem;
   logic [LANES-1:0]       next_spike;

   assign accept = in_valid && in_ready;

   lif_state_ram #(
      .DATA_W (RAM_W),
      .DEPTH  (DEPTH),
      .ADDR_W (IDX_W)
   ) u_state_ram (
      .clk     (clk),
      .rd_en   (s1_valid),
      .rd_addr (s1_idx),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   // Neuron update per lane. Each state word is {refrac, vmem}. The leak is a
   // signed multiply followed by an arithmetic shift, so negative membranes
   // round toward minus infinity.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic signed [WIDTH-1:0]  v_old, cur, v_dec, v_sum, v_sub, v_new;
      logic signed [PROD_W-1:0] prod;
      logic signed [WIDTH:0]    sum_wide, sub_wide;
      logic [REFRAC_W-1:0]      r_old, r_new;
      logic                     spike;

      assign v_old = $signed(rd_data[g*WORD_W +: WIDTH]);
      assign r_old = rd_data[g*WORD_W+WIDTH +: REFRAC_W];
      assign cur   = $signed(s2_current[g*WIDTH +: WIDTH]);
      assign prod  = PROD_W'(v_old) * PROD_W'($signed({1'b0, decay}));
      assign v_dec = WIDTH'(prod >>> DECAY_W);

      // One extra bit catches overflow; the top two bits disagree on overflow.
      assign sum_wide = (WIDTH+1)'(v_dec) + (WIDTH+1)'(cur);
      assign v_sum = (sum_wide[WIDTH] != sum_wide[WIDTH-1]) ?
                     (sum_wide[WIDTH] ? VMIN : VMAX) : sum_wide[WIDTH-1:0];
      assign sub_wide = (WIDTH+1)'(v_sum) - (WIDTH+1)'($signed(threshold));
      assign v_sub = (sub_wide[WIDTH] != sub_wide[WIDTH-1]) ?
                     (sub_wide[WIDTH] ? VMIN : VMAX) : sub_wide[WIDTH-1:0];

      // Refractory neurons ignore their input and sit at zero.
      always_comb begin
         spike = 1'b0;
         v_new = v_sum;
         r_new = r_old;
         if (r_old != '0) begin
            v_new = '0;
            r_new = r_old - REFRAC_W'(1);
         end else if (v_sum >= $signed(threshold)) begin
            spike = 1'b1;
            r_new = refrac_len;
            case (reset_mode)
               RESET_TO_ZERO:  v_new = '0;
               RESET_SUBTRACT: v_new = v_sub;
            endcase
         end
      end

      assign wr_word[g*WORD_W +: WORD_W] = {r_new, v_new};
      assign next_vmem[g*WIDTH +: WIDTH] = v_new;
      assign next_spike[g]               = spike;
   end

   // Write port: zeroes during the init sweep, otherwise write-back from the
   // compute stage. A clr in the compute cycle drops that write-back.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = s2_idx;
      wr_data = wr_word;
      if (state == ST_INIT) begin
         wr_en   = 1'b1;
         wr_addr = ptr;
         wr_data = '0;
      end else begin
         wr_en = s2_valid && !clr;
      end
   end

   // Controller, pipeline registers and registered outputs. ptr doubles as
   // the init sweep address and the running neuron index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         ptr        <= '0;
         in_ready   <= 1'b0;
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         s1_idx     <= '0;
         s2_idx     <= '0;
         s1_current <= '0;
         s2_current <= '0;
         out_valid  <= 1'b0;
         out_spike  <= '0;
         out_vmem   <= '0;
         out_idx    <= '0;
         step_done  <= 1'b0;
      end else if (clr) begin
         state      <= ST_INIT;
         ptr        <= '0;
         in_ready   <= 1'b0;
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         s1_idx     <= '0;
         s2_idx     <= '0;
         s1_current <= '0;
         s2_current <= '0;
         out_valid  <= 1'b0;
         out_spike  <= '0;
         out_vmem   <= '0;
         out_idx    <= '0;
         step_done  <= 1'b0;
      end else begin
         s1_valid   <= accept;
         s1_idx     <= ptr;
         s1_current <= in_current;
         s2_valid   <= s1_valid;
         s2_idx     <= s1_idx;
         s2_current <= s1_current;
         out_valid  <= s2_valid;
         step_done  <= s2_valid && (s2_idx == LAST_IDX);
         if (s2_valid) begin
            out_spike <= next_spike;
            out_vmem  <= next_vmem;
            out_idx   <= s2_idx;
         end
         case (state)
            ST_INIT: begin
               if (ptr == LAST_IDX) begin
                  ptr      <= '0;
                  state    <= ST_RUN;
                  in_ready <= 1'b1;
               end else begin
                  ptr <= ptr + IDX_W'(1);
               end
            end
            ST_RUN: begin
               if (accept) begin
                  ptr <= (ptr == LAST_IDX) ? '0 : ptr + IDX_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lif_neuron_bank.sv
// tb_lif_neuron_bank
// Self-checking bench for lif_neuron_bank (DEPTH=4, LANES=2). A behavioural
// model predicts every result when a beat is driven; predictions queue up in
// a scoreboard and are popped when out_valid appears.
module tb_lif_neuron_bank;

   localparam int WIDTH    = 25;
   localparam int DEPTH    = 4;
   localparam int LANES    = 2;
   localparam int DECAY_W  = 14;
   localparam int REFRAC_W = 4;
   localparam int IDX_W    = 2;
   localparam longint VMAX = 64'sd16777215;
   localparam longint VMIN = -64'sd16777216;

   logic                   clk;
   logic                   rst_n;
   logic                   clr;
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_current;
   logic [DECAY_W-1:0]     decay;
   logic [WIDTH-1:0]       threshold;
   logic [REFRAC_W-1:0]    refrac_len;
   logic                   reset_mode;
   logic                   out_valid;
   logic [LANES-1:0]       out_spike;
   logic [LANES*WIDTH-1:0] out_vmem;
   logic [IDX_W-1:0]       out_idx;
   logic                   step_done;

   typedef struct {
      int                     idx;
      logic [LANES-1:0]       spike;
      logic [LANES*WIDTH-1:0] vmem;
      logic                   sd;
      int                     cyc;
   } exp_t;

   exp_t   sb [$];
   longint mv [DEPTH][LANES];
   int     mr [DEPTH][LANES];
   int     mptr;
   int     cycle = 0;
   int     checks = 0;
   int     errors = 0;

   lif_neuron_bank #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .LANES    (LANES),
      .DECAY_W  (DECAY_W),
      .REFRAC_W (REFRAC_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_current (in_current),
      .decay      (decay),
      .threshold  (threshold),
      .refrac_len (refrac_len),
      .reset_mode (reset_mode),
      .out_valid  (out_valid),
      .out_spike  (out_spike),
      .out_vmem   (out_vmem),
      .out_idx    (out_idx),
      .step_done  (step_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Single point of comparison for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   function automatic longint sat(input longint x);
      if (x > VMAX) return VMAX;
      if (x < VMIN) return VMIN;
      return x;
   endfunction

   function automatic void resetModel();
      for (int i = 0; i < DEPTH; i++) begin
         for (int l = 0; l < LANES; l++) begin
            mv[i][l] = 0;
            mr[i][l] = 0;
         end
      end
      mptr = 0;
   endfunction

   // Drive one beat and push the predicted result. Parameters are only changed
   // while the pipeline is empty, so reading them here matches the compute cycle.
   task automatic applyStimulus(input longint c0, input longint c1);
      exp_t   e;
      longint cur [LANES];
      longint thr, vsum, vnew;
      cur[0] = c0;
      cur[1] = c1;
      @(negedge clk);
      in_valid = 1'b1;
      for (int l = 0; l < LANES; l++) in_current[l*WIDTH +: WIDTH] = WIDTH'(cur[l]);
      checkOutput("rdy_at_beat", 64'(in_ready), 64'd1);
      thr     = longint'($signed(threshold));
      e.idx   = mptr;
      e.spike = '0;
      e.vmem  = '0;
      e.sd    = (mptr == DEPTH - 1);
      e.cyc   = cycle + 1;
      for (int l = 0; l < LANES; l++) begin
         if (mr[mptr][l] != 0) begin
            mr[mptr][l] = mr[mptr][l] - 1;
            vnew = 0;
         end else begin
            vsum = sat(((mv[mptr][l] * longint'(decay)) >>> DECAY_W) + cur[l]);
            if (vsum >= thr) begin
               e.spike[l] = 1'b1;
               mr[mptr][l] = int'(refrac_len);
               vnew = reset_mode ? sat(vsum - thr) : 0;
            end else begin
               vnew = vsum;
            end
         end
         mv[mptr][l] = vnew;
         e.vmem[l*WIDTH +: WIDTH] = WIDTH'(vnew);
      end
      sb.push_back(e);
      mptr = (mptr + 1) % DEPTH;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drainScoreboard();
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic checkInitSweep(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         #1 checkOutput({tag, "_rdy_low"}, 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      #1 checkOutput({tag, "_rdy_high"}, 64'(in_ready), 64'd1);
   endtask

   // Result monitor: every out_valid must match the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_valid", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("out_idx", 64'(out_idx), 64'(e.idx));
            checkOutput("out_spike", 64'(out_spike), 64'(e.spike));
            checkOutput("out_vmem", 64'(out_vmem), 64'(e.vmem));
            checkOutput("step_done", 64'(step_done), 64'(e.sd));
            checkOutput("latency", 64'(cycle - e.cyc), 64'd2);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      clr        = 1'b0;
      in_valid   = 1'b0;
      in_current = '0;
      decay      = 14'd8192;
      threshold  = WIDTH'(VMAX);
      refrac_len = 4'd0;
      reset_mode = 1'b0;
      resetModel();
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_spike", 64'(out_spike), 64'd0);
      checkOutput("rst_out_vmem", 64'(out_vmem), 64'd0);
      checkOutput("rst_out_idx", 64'(out_idx), 64'd0);
      checkOutput("rst_step_done", 64'(step_done), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      checkInitSweep("init");

      // Leak/integration plus wrap: 12 back-to-back beats over 3 sweeps.
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      applyStimulus(1000, -999);
      applyStimulus(5, 7);
      applyStimulus(-5, 300);
      applyStimulus(0, 0);
      applyStimulus(1000, -999);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      applyStimulus(0, 0);
      drainScoreboard();

      // Spike and refractory, reset-to-zero.
      decay = 14'd0;
      threshold = 25'd900;
      refrac_len = 4'd2;
      reset_mode = 1'b0;
      for (int s = 0; s < 4; s++) begin
         applyStimulus((s == 3) ? 500 : 1000, 0);
         applyStimulus(100, 950);
         applyStimulus(100, 950);
         applyStimulus(100, 950);
      end
      drainScoreboard();

      // Subtract mode around the threshold.
      refrac_len = 4'd0;
      reset_mode = 1'b1;
      applyStimulus(1000, 0);
      applyStimulus(899, -5);
      applyStimulus(900, 0);
      applyStimulus(0, 0);
      drainScoreboard();

      // Saturation at both rails, with a decay carry on top of full-scale input.
      decay = 14'd16383;
      threshold = WIDTH'(-1);
      for (int i = 0; i < DEPTH; i++) applyStimulus(64'sd16777215, VMIN);
      drainScoreboard();

      // Random currents and parameters with gaps between beats.
      decay = DECAY_W'($urandom_range(0, 16383));
      threshold = 25'd3000;
      refrac_len = 4'd1;
      reset_mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
         applyStimulus(longint'($urandom_range(0, 6000)) - 3000,
                       longint'($urandom_range(0, 6000)) - 3000);
         idleCycles(int'($urandom_range(0, 2)));
      end
      drainScoreboard();

      // clr with two beats in flight: both results must vanish and the
      // state must come back zeroed after a fresh init sweep.
      applyStimulus(2000, 2000);
      applyStimulus(2000, 2000);
      @(negedge clk);
      clr = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      resetModel();
      @(negedge clk);
      clr = 1'b0;
      checkInitSweep("clr");
      decay = 14'd8192;
      for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0);
      drainScoreboard();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
